// File: rtl/hit_scan_array_if.sv
// Bundle of the scan request, object/player coordinates and scan results
// exchanged between the game logic (master) and hit_scan_array (slave).
interface hit_scan_array_if #(
    parameter int NUM_OBJ = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
);
    logic                   start;
    logic [NUM_OBJ*X_W-1:0] obj_x;
    logic [NUM_OBJ*Y_W-1:0] obj_y;
    logic [NUM_OBJ-1:0]     obj_valid;
    logic [X_W-1:0]         ply_x;
    logic [Y_W-1:0]         ply_y;
    logic                   busy;
    logic                   done;
    logic                   hit;
    logic [NUM_OBJ-1:0]     hit_mask;
    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W:0]         hit_cnt;

    modport master (
        output start, obj_x, obj_y, obj_valid, ply_x, ply_y,
        input  busy, done, hit, hit_mask, hit_idx, hit_cnt
    );

    modport slave (
        input  start, obj_x, obj_y, obj_valid, ply_x, ply_y,
        output busy, done, hit, hit_mask, hit_idx, hit_cnt
    );
endinterface

// File: rtl/hit_scan_array.sv
// Sequential collision scanner: tests one object per clock against a hit zone around the player.
// Macro HIT_FULL_DIAMOND_EN makes the lower half a diamond too; otherwise it is a square.
module hit_scan_array #(
    parameter int NUM_OBJ = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int OFF_X   = 40,
    parameter int OFF_Y   = 41,
    parameter int RADIUS  = 38,
    parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    hit_scan_array_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int XC  = X_W + 1;
    localparam int YC  = Y_W + 1;
    localparam int XD  = X_W + 2;
    localparam int YD  = Y_W + 2;
    localparam int SW  = ((X_W > Y_W) ? X_W : Y_W) + 3;
    localparam int CW  = IDX_W + 1;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_OBJ - 1);
    localparam logic [XC-1:0]    OFFX  = XC'(OFF_X);
    localparam logic [YC-1:0]    OFFY  = YC'(OFF_Y);
    localparam logic [XD-1:0]    RAD_X = XD'(RADIUS);
    localparam logic [YD-1:0]    RAD_Y = YD'(RADIUS);
    localparam logic [SW-1:0]    RAD_S = SW'(RADIUS);

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [X_W-1:0]     ox [NUM_OBJ];
    logic [Y_W-1:0]     oy [NUM_OBJ];
    logic [NUM_OBJ-1:0] ov;
    logic [XC-1:0]      cx;
    logic [YC-1:0]      cy;

    logic               hit_q;
    logic [NUM_OBJ-1:0] mask_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CW-1:0]      cnt_q;

    logic [XD-1:0]      dx;
    logic [YD-1:0]      dy;
    logic [XD-1:0]      adx;
    logic [YD-1:0]      ady;
    logic [SW-1:0]      sum;
    logic               sq;
    logic               dia;
    logic               lower_hit;
    logic               in_zone;
    logic               obj_hit;

    // Zero-extended operands keep the difference exact; the top bit is the sign.
    always_comb begin
        dx  = {2'b00, ox[ptr]} - {1'b0, cx};
        dy  = {2'b00, oy[ptr]} - {1'b0, cy};
        adx = dx[XD-1] ? -dx : dx;
        ady = dy[YD-1] ? -dy : dy;
        sum = SW'(adx) + SW'(ady);
        sq  = (adx < RAD_X) && (ady < RAD_Y);
        dia = sum < RAD_S;
`ifdef HIT_FULL_DIAMOND_EN
        lower_hit = sq && dia;
`else
        lower_hit = sq;
`endif
        in_zone = dy[YD-1] ? (sq && dia) : lower_hit;
        obj_hit = (state == SCAN) && ov[ptr] && in_zone;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            ov     <= '0;
            cx     <= '0;
            cy     <= '0;
            hit_q  <= 1'b0;
            mask_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                ox[i] <= '0;
                oy[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= bus.start ? LOAD : IDLE;
                end
                LOAD: begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        ox[i] <= bus.obj_x[i*X_W +: X_W];
                        oy[i] <= bus.obj_y[i*Y_W +: Y_W];
                    end
                    ov     <= bus.obj_valid;
                    cx     <= {1'b0, bus.ply_x} + OFFX;
                    cy     <= {1'b0, bus.ply_y} + OFFY;
                    hit_q  <= 1'b0;
                    mask_q <= '0;
                    idx_q  <= '0;
                    cnt_q  <= '0;
                    ptr    <= '0;
                    state  <= SCAN;
                end
                SCAN: begin
                    // Only the first hit loads the index, so it ends up as the lowest one.
                    if (obj_hit) begin
                        mask_q[ptr] <= 1'b1;
                        cnt_q       <= cnt_q + CW'(1);
                        if (!hit_q) begin
                            hit_q <= 1'b1;
                            idx_q <= ptr;
                        end
                    end
                    if (ptr == LAST) begin
                        state <= DONE;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state == LOAD) || (state == SCAN);
    assign bus.done     = (state == DONE);
    assign bus.hit      = hit_q;
    assign bus.hit_mask = mask_q;
    assign bus.hit_idx  = idx_q;
    assign bus.hit_cnt  = cnt_q;
endmodule

// File: tb/tb_hit_scan_array.sv
// Directed table-driven bench for hit_scan_array with NUM_OBJ=4, player at (100,100),
// so the hit centre sits at (140,141).
module tb_hit_scan_array;
    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int IW = 2;

    typedef struct {
        string        name;
        logic [N*XW-1:0] ox;
        logic [N*YW-1:0] oy;
        logic [N-1:0] valid;
        logic         exp_hit;
        logic [N-1:0] exp_mask;
        logic [IW-1:0] exp_idx;
        logic [IW:0]  exp_cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vec_count  = 0;
    int   miss_count = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    hit_scan_array_if #(.NUM_OBJ(N), .X_W(XW), .Y_W(YW), .IDX_W(IW)) bus ();

    hit_scan_array #(.NUM_OBJ(N), .X_W(XW), .Y_W(YW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input string nm,
                                input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int x3, input int y3,
                                input logic [N-1:0] v, input logic h, input logic [N-1:0] m,
                                input int idx, input int cnt);
        vec_t r;
        r.name     = nm;
        r.ox       = {XW'(x3), XW'(x2), XW'(x1), XW'(x0)};
        r.oy       = {YW'(y3), YW'(y2), YW'(y1), YW'(y0)};
        r.valid    = v;
        r.exp_hit  = h;
        r.exp_mask = m;
        r.exp_idx  = IW'(idx);
        r.exp_cnt  = (IW+1)'(cnt);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulses start with the vector's inputs and returns the number of edges until done.
    task automatic apply_stimulus(input vec_t v, output int lat);
        @(negedge clk);
        bus.obj_x     = v.ox;
        bus.obj_y     = v.oy;
        bus.obj_valid = v.valid;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_output({v.name, ".busy_load"}, 64'(bus.busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input vec_t v);
        check_output({v.name, ".hit"},  64'(bus.hit),      64'(v.exp_hit));
        check_output({v.name, ".mask"}, 64'(bus.hit_mask), 64'(v.exp_mask));
        check_output({v.name, ".idx"},  64'(bus.hit_idx),  64'(v.exp_idx));
        check_output({v.name, ".cnt"},  64'(bus.hit_cnt),  64'(v.exp_cnt));
    endtask

    task automatic check_zero(input string name);
        check_output({name, ".busy"}, 64'(bus.busy),     64'd0);
        check_output({name, ".done"}, 64'(bus.done),     64'd0);
        check_output({name, ".hit"},  64'(bus.hit),      64'd0);
        check_output({name, ".mask"}, 64'(bus.hit_mask), 64'd0);
        check_output({name, ".idx"},  64'(bus.hit_idx),  64'd0);
        check_output({name, ".cnt"},  64'(bus.hit_cnt),  64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int   lat;
        int   dones;
        vec_t c;

        vecs[0] = mk("top_hit",    140,120, 0,0, 0,0, 0,0, 4'b0001, 1'b1, 4'b0001, 0, 1);
        vecs[1] = mk("top_sum40",  0,0, 160,121, 0,0, 0,0, 4'b0010, 1'b0, 4'b0000, 0, 0);
`ifdef HIT_FULL_DIAMOND_EN
        vecs[2] = mk("low_corner", 0,0, 0,0, 160,161, 0,0, 4'b0100, 1'b0, 4'b0000, 0, 0);
        vecs[8] = mk("low_37_37",  177,178, 140,179, 0,0, 0,0, 4'b0011, 1'b0, 4'b0000, 0, 0);
`else
        vecs[2] = mk("low_corner", 0,0, 0,0, 160,161, 0,0, 4'b0100, 1'b1, 4'b0100, 2, 1);
        vecs[8] = mk("low_37_37",  177,178, 140,179, 0,0, 0,0, 4'b0011, 1'b1, 4'b0001, 0, 1);
`endif
        vecs[3] = mk("dx_edge",    178,141, 0,0, 0,0, 177,141, 4'b1001, 1'b1, 4'b1000, 3, 1);
        vecs[4] = mk("all_centre", 140,141, 140,141, 140,141, 140,141, 4'b1111, 1'b1, 4'b1111, 0, 4);
        vecs[5] = mk("none_valid", 140,141, 140,141, 140,141, 140,141, 4'b0000, 1'b0, 4'b0000, 0, 0);
        vecs[6] = mk("sum_edge",   0,0, 150,113, 150,114, 0,0, 4'b0110, 1'b1, 4'b0100, 2, 1);
        vecs[7] = mk("neg_side",   103,141, 102,141, 140,104, 140,178, 4'b1111, 1'b1, 4'b1101, 0, 3);
        vecs[9] = mk("far_wrap",   1023,141, 140,511, 0,0, 141,142, 4'b1111, 1'b1, 4'b1000, 3, 1);

        bus.start     = 1'b0;
        bus.obj_x     = '0;
        bus.obj_y     = '0;
        bus.obj_valid = '0;
        bus.ply_x     = XW'(100);
        bus.ply_y     = YW'(100);

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle");

        for (int k = 0; k < 10; k++) begin
            apply_stimulus(vecs[k], lat);
            check_output({vecs[k].name, ".latency"}, 64'(lat), 64'd5);
            check_output({vecs[k].name, ".busy_done"}, 64'(bus.busy), 64'd0);
            check_result(vecs[k]);
            @(posedge clk);
            #1;
            check_output({vecs[k].name, ".done_width"}, 64'(bus.done), 64'd0);
            check_result(vecs[k]);
        end

        // Inputs zeroed after capture and a start pulse during the scan must change nothing.
        c = mk("frozen", 140,141, 140,141, 140,141, 140,141, 4'b1011, 1'b1, 4'b1011, 0, 3);
        @(negedge clk);
        bus.obj_x     = c.ox;
        bus.obj_y     = c.oy;
        bus.obj_valid = c.valid;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.obj_x = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) check_result(c);
            end
            @(posedge clk);
            #1;
        end
        check_output("frozen.done_pulses", 64'(dones), 64'd1);
        check_result(c);

        // Async reset with two hits already recorded at ptr=2.
        c = mk("abort", 140,141, 140,141, 140,141, 140,141, 4'b1111, 1'b1, 4'b0011, 0, 2);
        @(negedge clk);
        bus.obj_x     = c.ox;
        bus.obj_y     = c.oy;
        bus.obj_valid = c.valid;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_result(c);
        rst_n = 1'b0;
        #1;
        check_zero("abort_rst");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check_output("abort.done_pulses", 64'(dones), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(vecs[7], lat);
        check_output("after_abort.latency", 64'(lat), 64'd5);
        check_result(vecs[7]);

        // start during the DONE cycle goes straight to LOAD.
        check_output("chain.done_seen", 64'(bus.done), 64'd1);
        bus.obj_x     = vecs[0].ox;
        bus.obj_y     = vecs[0].oy;
        bus.obj_valid = vecs[0].valid;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_output("chain.busy_load", 64'(bus.busy), 64'd1);
        check_output("chain.done_low", 64'(bus.done), 64'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check_output("chain.latency", 64'(lat), 64'd5);
        check_result(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/hit_scan_array.md
# hit_scan_array

Multi-object collision scanner for the airplane game. Each frame it snapshots up to NUM_OBJ object coordinates (enemy bullets or planes) and the player position. It then tests one object per clock against a diamond-shaped hit zone around the player's centre. It reports a sticky hit flag, a per-object hit mask, the lowest hit index and a hit count. It sits between the object position generators and the game-state/life-counter logic and replaces per-bullet single-pair checkers.

## Interface
- NUM_OBJ, 8, number of object channels (1..64)
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- OFF_X, 40, offset from player sprite origin to hit centre, x
- OFF_Y, 41, offset from player sprite origin to hit centre, y
- RADIUS, 38, hit radius (strict less-than)
- IDX_W, $clog2(NUM_OBJ) (min 1), index width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a scan
- obj_x  in  NUM_OBJ*X_W  packed object x, channel i at [i*X_W +: X_W]
- obj_y  in  NUM_OBJ*Y_W  packed object y, same packing
- obj_valid  in  NUM_OBJ  channel i takes part in the scan only when 1
- ply_x  in  X_W  player sprite origin x
- ply_y  in  Y_W  player sprite origin y
- busy  out  1  high in LOAD and SCAN
- done  out  1  one-cycle pulse when results are final
- hit  out  1  at least one object hit in the last completed scan
- hit_mask  out  NUM_OBJ  bit i set when object i hit
- hit_idx  out  IDX_W  lowest hit index, 0 if none
- hit_cnt  out  IDX_W+1  number of hits

## Operation
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE/DONE + start → LOAD. start is ignored while busy.
- LOAD (1 cycle):
  - register all obj_x/obj_y/obj_valid.
  - register cx = ply_x + OFF_X and cy = ply_y + OFF_Y at widths X_W+1 and Y_W+1, with no wrap.
  - clear hit, hit_mask, hit_idx and hit_cnt; set ptr = 0.
- SCAN (one object per cycle, ptr 0..NUM_OBJ-1):
  - dx = obj_x[ptr] − cx, signed, X_W+2 bits; dy = obj_y[ptr] − cy, signed, Y_W+2 bits.
  - Square test: |dx| < RADIUS and |dy| < RADIUS.
  - Upper half (dy < 0): hit when the square test passes and |dx| + |dy| < RADIUS.
  - Lower half (dy ≥ 0): rule set by the Configuration section.
  - On a hit of a valid channel:
    - set hit_mask[ptr] and increment hit_cnt.
    - set hit on the first hit only, and load hit_idx with ptr.
  - ptr == NUM_OBJ−1 → DONE; otherwise ptr + 1.
- DONE: assert done for exactly this one cycle, then go to IDLE.
- Results hold until the next LOAD clears them.
- Input changes after LOAD do not affect the running scan.

## Timing
- Reset values: busy 0, done 0, hit 0, hit_mask 0, hit_idx 0, hit_cnt 0. FSM goes to IDLE and ptr to 0.
- start sampled at edge T → LOAD at T+1 → SCAN from T+2 to T+NUM_OBJ+1.
- done high in cycle T+NUM_OBJ+2. Results are valid in that same cycle.
- busy high from T+1 through T+NUM_OBJ+1.
- start in the DONE cycle is accepted; LOAD follows directly.
- rst_n asserted mid-scan aborts immediately. No done pulse is issued.
- obj_valid = 0: the channel never hits, regardless of its coordinates.
- Boundary: |dx| + |dy| == RADIUS is a miss. |dx| == RADIUS is a miss.

## Configuration
- HIT_FULL_DIAMOND_EN defined: the lower half uses the same diamond rule as the upper half, giving a symmetric hit zone.
- Not defined: the lower half (dy ≥ 0) hits on the square test alone, so the hit zone is a diamond top on a square bottom.

## Test plan
All scenarios use NUM_OBJ=4, defaults, ply=(100,100), so the hit centre is (140,141).

- obj0=(140,120), valid=0001, start → done at start+6; hit=1, hit_mask=0001, hit_idx=0, hit_cnt=1.
- obj1=(160,121) (dx=20, dy=−20, sum 40), valid=0010 → hit=0, hit_mask=0000, in both configurations.
- obj2=(160,161) (dx=20, dy=20), valid=0100 → without macro: hit=1, hit_mask=0100. With HIT_FULL_DIAMOND_EN: hit=0.
- obj0=(178,141), obj3=(177,141), valid=1001 → hit_mask=1000, hit_idx=3, hit_cnt=1.
- All four objects at (140,141), valid=1011; change all obj_x to 0 the cycle after LOAD; pulse start mid-scan → hit_mask=1011, hit_idx=0, hit_cnt=3, exactly one done pulse.
- Scan running, rst_n low during SCAN ptr=2 → all outputs 0 in the same cycle, no done pulse. Next start after release gives a normal result.
